// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int ZERO_ADDR = 0;

    // LSB position of port k inside a packed bus of w-bit fields.
    function automatic int slice_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: walks every entry once, one per cycle, while clr_busy is high.
//
// state    | meaning
// ST_IDLE  | sweep finished, normal register file operation
// ST_CLEAR | zeroing entry clr_idx this cycle, writes and reads blocked
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              startin,
    output logic              clr_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              clr_busy_q, clr_busy_d;

    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        clr_busy_d = clr_busy_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == LAST_IDX) begin
                state_d    = ST_IDLE;
                clr_busy_d = 1'b0;
                clr_idx_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (startin) begin
            state_q    <= ST_CLEAR;
            clr_idx_q  <= '0;
            clr_busy_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    // No clearing on the restart edge itself; the restarted sweep covers every entry anyway.
    assign clr_we   = (state_q == ST_CLEAR) && !startin;
    assign clr_addr = clr_idx_q;
    assign clr_busy = clr_busy_q;

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file: NUM_RD combinational read ports, two write ports, debug read port.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     startin,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    output logic                     clr_busy
);

    // Per-address masks: which addresses exist, and which are real (writable, readable) storage.
    localparam int                ASPACE     = 1 << ADDR_W;
    localparam logic [ASPACE-1:0] IN_RANGE   = {ASPACE{1'b1}} >> (ASPACE - NUM_REGS);
    localparam logic [ASPACE-1:0] ZERO_MASK  = (ZERO_REG != 0) ? (ASPACE'(1) << ZERO_ADDR) : '0;
    localparam logic [ASPACE-1:0] ACCESSIBLE = IN_RANGE & ~ZERO_MASK;

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr0_ok, wr1_ok;

    regfile_clear_fsm #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_clear_fsm (
        .clk      (clk),
        .startin  (startin),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr0_ok = wr0_en && !clr_busy && ACCESSIBLE[wr0_addr];
    assign wr1_ok = wr1_en && !clr_busy && ACCESSIBLE[wr1_addr];

    // Port 1 is applied last so it wins an address collision.
    always_comb begin
        mem_d = mem_q;
        if (clr_we) mem_d[clr_addr] = '0;
        if (wr0_ok) mem_d[wr0_addr] = wr0_data;
        if (wr1_ok) mem_d[wr1_addr] = wr1_data;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] stored;
        logic [DATA_W-1:0] value;

        assign addr   = rd_addr[slice_lsb(k, ADDR_W) +: ADDR_W];
        assign stored = (!clr_busy && ACCESSIBLE[addr]) ? mem_q[addr] : '0;
`ifdef REGFILE_BYPASS_EN
        assign value  = (wr1_ok && (addr == wr1_addr)) ? wr1_data :
                        (wr0_ok && (addr == wr0_addr)) ? wr0_data : stored;
`else
        assign value  = stored;
`endif
        assign rd_data[slice_lsb(k, DATA_W) +: DATA_W] = value;
    end

    assign dbg_data = (!clr_busy && ACCESSIBLE[dbg_addr]) ? mem_q[dbg_addr] : '0;

endmodule

// File: tb/tb_regfile_multiport.sv
// Randomized scoreboard bench for regfile_multiport against an array-based reference model.
module tb_regfile_multiport;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int NUM_RD   = 2;

    logic                     clk = 1'b0;
    logic                     startin;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr0_en, wr1_en;
    logic [ADDR_W-1:0]        wr0_addr, wr1_addr, dbg_addr;
    logic [DATA_W-1:0]        wr0_data, wr1_data, dbg_data;
    logic                     clr_busy;

    always #5 clk = ~clk;

    regfile_multiport #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .startin  (startin),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .clr_busy (clr_busy)
    );

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] rd0;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] dbg;
        logic              busy;
    } exp_t;

    exp_t              exp_q[$];
    int                n_checks = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    bit                checking = 0;
    logic [DATA_W-1:0] model [NUM_REGS];
    int                busy_rem = 0;

    // Reference: during a sweep everything reads 0; entry 0 always reads 0.
    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a, input bit fwd);
        if (busy_rem > 0) return '0;
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (fwd && wr1_en && wr1_addr == a) return wr1_data;
        if (fwd && wr0_en && wr0_addr == a) return wr0_data;
`endif
        return model[a];
    endfunction

    task automatic drive(input bit st,
                         input bit w0e, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input bit w1e, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                         input logic [ADDR_W-1:0] r0, input logic [ADDR_W-1:0] r1,
                         input logic [ADDR_W-1:0] dba);
        exp_t e;
        startin  = st;
        wr0_en   = w0e;  wr0_addr = a0;  wr0_data = d0;
        wr1_en   = w1e;  wr1_addr = a1;  wr1_data = d1;
        rd_addr  = {r1, r0};
        dbg_addr = dba;
        if (checking) begin
            e.cyc  = cyc;
            e.rd0  = exp_read(r0, 1'b1);
            e.rd1  = exp_read(r1, 1'b1);
            e.dbg  = exp_read(dba, 1'b0);
            e.busy = (busy_rem > 0);
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (st) begin
            foreach (model[i]) model[i] = '0;
            busy_rem = NUM_REGS;
        end else if (busy_rem > 0) begin
            busy_rem--;
        end else begin
            if (w0e && a0 != 0) model[a0] = d0;
            if (w1e && a1 != 0) model[a1] = d1;
        end
        #1;
        cyc++;
    endtask

    function automatic logic [ADDR_W-1:0] ra();
        return ADDR_W'($urandom_range(0, NUM_REGS - 1));
    endfunction

    // Narrow address range so the two write ports and the read ports collide often.
    function automatic logic [ADDR_W-1:0] ra_hot();
        return ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7)) : ra();
    endfunction

    task automatic idle(input logic [ADDR_W-1:0] r0, input logic [ADDR_W-1:0] r1,
                        input logic [ADDR_W-1:0] dba);
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, r0, r1, dba);
    endtask

    task automatic check(input string name, input int c,
                         input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("clr_busy", e.cyc, DATA_W'(clr_busy), DATA_W'(e.busy));
                check("rd0", e.cyc, rd_data[DATA_W-1:0], e.rd0);
                check("rd1", e.cyc, rd_data[2*DATA_W-1:DATA_W], e.rd1);
                check("dbg", e.cyc, dbg_data, e.dbg);
            end
        end
    end

    initial begin : stim
        startin = 1'b1;
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        rd_addr = '0;  dbg_addr = '0;
        @(posedge clk);
        #1;
        foreach (model[i]) model[i] = '0;
        busy_rem = NUM_REGS;
        checking = 1'b1;

        // Reset, full sweep, then every entry via debug port.
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, ra(), ra(), ra());
        repeat (NUM_REGS) idle(ra(), ra(), ra());
        for (int i = 0; i < NUM_REGS; i++) idle(ra(), ra(), ADDR_W'(i));

        // Simple write/read and zero register.
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 5'd5, 5'd0, 5'd5);
        idle(5'd5, 5'd0, 5'd5);
        drive(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, '0, '0, 5'd0, 5'd5, 5'd0);
        idle(5'd0, 5'd5, 5'd0);

        // Same-address collision, port 1 wins.
        drive(1'b0, 1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 5'd7, 5'd7, 5'd7);
        idle(5'd7, 5'd7, 5'd7);

        // Same-cycle read of a write in flight.
        drive(1'b0, 1'b1, 5'd3, 32'hA5, 1'b0, '0, '0, 5'd3, 5'd7, 5'd3);
        idle(5'd3, 5'd3, 5'd3);

        // Preload, reset, restart mid-sweep, dropped write during sweep.
        for (int i = 1; i < NUM_REGS; i++)
            drive(1'b0, 1'b1, ADDR_W'(i), $urandom, 1'b1, ra(), $urandom, ra(), ra(), ra());
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, ra(), ra(), ra());
        repeat (9) idle(ra(), ra(), ra());
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, ra(), ra(), ra());
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i == 5) drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 32'hCAFE, 5'd9, ra(), 5'd9);
            else        idle(ra(), ra(), ra());
        end
        idle(5'd9, 5'd9, 5'd9);
        for (int i = 0; i < NUM_REGS; i++) idle(ra(), ra(), ADDR_W'(i));

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 249) == 0,
                  $urandom_range(0, 1) == 1, ra_hot(), $urandom,
                  $urandom_range(0, 1) == 1, ra_hot(), $urandom,
                  ra_hot(), ra_hot(), ra_hot());
        end
        idle(ra(), ra(), ra());

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
